// File: rtl/ascon_permutation_engine.sv
// ASCON p^N permutation engine: UNROLL rounds per clock, N chosen per operation.
// ascon_pkg holds the state type, round constants, S-box table and a single-round function.
package ascon_pkg;

  // Lane x0 sits at index 0, the most significant end, so {x0,x1,x2,x3,x4} concatenates naturally.
  typedef logic [0:4][63:0] t_state_array;

  localparam logic [7:0] ROUND_CONSTANTS [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  localparam logic [7:0] S_TABLE [32] = '{
    8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
    8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
    8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
    8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17
  };

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic t_state_array ascon_round(input t_state_array s, input logic [3:0] c);
    t_state_array t;
    logic [4:0]   col;
    logic [4:0]   sb;
    t = s;
    if (c < 4'd12) t[2][7:0] = t[2][7:0] ^ ROUND_CONSTANTS[c];
    for (int i = 0; i < 64; i++) begin
      col = {t[0][i], t[1][i], t[2][i], t[3][i], t[4][i]};
      sb  = S_TABLE[col][4:0];
      {t[0][i], t[1][i], t[2][i], t[3][i], t[4][i]} = sb;
    end
    t[0] = t[0] ^ ror64(t[0], 19) ^ ror64(t[0], 28);
    t[1] = t[1] ^ ror64(t[1], 61) ^ ror64(t[1], 39);
    t[2] = t[2] ^ ror64(t[2], 1)  ^ ror64(t[2], 6);
    t[3] = t[3] ^ ror64(t[3], 10) ^ ror64(t[3], 17);
    t[4] = t[4] ^ ror64(t[4], 7)  ^ ror64(t[4], 41);
    return t;
  endfunction

endpackage

module ascon_permutation_engine
  import ascon_pkg::*;
#(
  parameter int UNROLL  = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [3:0]   i_num_rounds,
  input  t_state_array i_state,
  output logic         o_ready,
  output logic         o_done,
  output t_state_array o_state,
  output logic [3:0]   o_round_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  fsm_e         fsm_q;
  t_state_array work_q;
  t_state_array result_q;
  t_state_array step_out;
  logic [3:0]   rc_idx_q;
  logic [3:0]   remaining_q;
  logic [3:0]   n_clamped;
  logic [3:0]   rc_start;
  logic         accept;
  logic         last_step;

  assign accept    = i_start & o_ready;
  assign last_step = remaining_q <= 4'(UNROLL);
  assign n_clamped = (i_num_rounds > 4'd12) ? 4'd12 : i_num_rounds;
  // N=0 has no round to run; park the index at 11 so it never leaves 0..11.
  assign rc_start  = (n_clamped == 4'd0) ? 4'd11 : 4'd12 - n_clamped;

  // Unrolled round chain; stages past the remaining count pass the state through.
  always_comb begin : p_chain
    t_state_array s;
    // NOTE: assign a default before any conditional update so no path leaves a latch.
    s = work_q;
    for (int k = 0; k < UNROLL; k++) begin
      // NOTE: blocking '=' here so each stage consumes the previous stage's value in the same cycle.
      if (4'(k) < remaining_q) s = ascon_round(s, rc_idx_q + 4'(k));
    end
    step_out = s;
  end

  // NOTE: non-blocking '<=' for every register so all updates see pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= S_IDLE;
      work_q      <= '0;
      result_q    <= '0;
      rc_idx_q    <= '0;
      remaining_q <= '0;
      o_ready     <= 1'b1;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (fsm_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            work_q      <= i_state;
            rc_idx_q    <= rc_start;
            remaining_q <= n_clamped;
            o_ready     <= 1'b0;
            fsm_q       <= S_RUN;
          end else begin
            fsm_q       <= S_IDLE;
          end
        end
        S_RUN: begin
          work_q <= step_out;
          if (last_step) begin
            // rc_idx_q is left on the last batch start so it never reaches 12.
            result_q    <= step_out;
            remaining_q <= '0;
            o_done      <= 1'b1;
            o_ready     <= 1'b1;
            fsm_q       <= S_DONE;
          end else begin
            rc_idx_q    <= rc_idx_q + 4'(UNROLL);
            remaining_q <= remaining_q - 4'(UNROLL);
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  // In DONE remaining_q is zero, so the chain output equals the captured result.
  if (OUT_REG) begin : g_out_reg
    assign o_state = result_q;
  end else begin : g_out_comb
    assign o_state = (fsm_q == S_DONE) ? step_out : result_q;
  end

  assign o_round_idx = rc_idx_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Bench for ascon_permutation_engine: six instances (UNROLL 1,2,3,4,6,12, mixed OUT_REG)
// against a bitsliced boolean reference of the ASCON permutation.
module tb_ascon_permutation_engine;
  import ascon_pkg::*;

  localparam int NDUT = 6;
  localparam int UNR [NDUT] = '{1, 2, 3, 4, 6, 12};

  logic         clock = 1'b0;
  logic         reset_n;
  logic         i_start;
  logic [5:0]   start_mask;
  logic [3:0]   i_num_rounds;
  t_state_array i_state;

  logic         ready  [NDUT];
  logic         done   [NDUT];
  t_state_array ostate [NDUT];
  logic [3:0]   ridx   [NDUT];
  t_state_array cap    [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ascon_permutation_engine #(.UNROLL(UNR[g]), .OUT_REG(g % 2 == 0)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_start      (i_start & start_mask[g]),
      .i_num_rounds (i_num_rounds),
      .i_state      (i_state),
      .o_ready      (ready[g]),
      .o_done       (done[g]),
      .o_state      (ostate[g]),
      .o_round_idx  (ridx[g])
    );
  end

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference permutation: constants from the (15-r, r) nibble rule, S-box as boolean equations.
  function automatic t_state_array model_perm(input t_state_array s, input int n);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    for (int r = 12 - n; r < 12; r++) begin
      x2 = x2 ^ 64'(((15 - r) << 4) | r);
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic t_state_array rand_state();
    t_state_array s;
    for (int l = 0; l < 5; l++) s[l] = {$urandom, $urandom};
    return s;
  endfunction

  // Launch one operation on the masked instances and watch a fixed 14-cycle window.
  task automatic do_operation(input logic [5:0] mask, input logic [3:0] n,
                              input t_state_array st, input string tag);
    t_state_array exp_s;
    int nn;
    int exp_lat;
    int lat   [NDUT];
    int ndone [NDUT];
    nn    = (n > 4'd12) ? 12 : int'(n);
    exp_s = model_perm(st, nn);
    @(negedge clock);
    start_mask = mask; i_start = 1'b1; i_num_rounds = n; i_state = st;
    @(negedge clock);
    i_start = 1'b0; i_num_rounds = 4'($urandom); i_state = rand_state();
    for (int g = 0; g < NDUT; g++) begin
      lat[g] = -1; ndone[g] = 0;
      if (mask[g]) begin
        checks++;
        if (ready[g] !== 1'b0) begin
          errors++; $display("FAIL %s busy_ready u%0d: got %b expected 0", tag, UNR[g], ready[g]);
        end
        if (nn > 0) begin
          checks++;
          if (ridx[g] !== 4'(12 - nn)) begin
            errors++; $display("FAIL %s first_rc_idx u%0d: got %0d expected %0d", tag, UNR[g], ridx[g], 12 - nn);
          end
        end
      end
    end
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      for (int g = 0; g < NDUT; g++) begin
        if (mask[g] && done[g] === 1'b1) begin
          ndone[g]++;
          if (lat[g] < 0) begin lat[g] = c; cap[g] = ostate[g]; end
        end
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      if (mask[g]) begin
        exp_lat = (nn == 0) ? 1 : (nn + UNR[g] - 1) / UNR[g];
        checks++;
        if (ndone[g] != 1) begin
          errors++; $display("FAIL %s done_pulses u%0d: got %0d expected 1", tag, UNR[g], ndone[g]);
        end
        checks++;
        if (lat[g] != exp_lat) begin
          errors++; $display("FAIL %s latency u%0d: got %0d expected %0d", tag, UNR[g], lat[g], exp_lat);
        end
        checks++;
        if (cap[g] !== exp_s) begin
          errors++; $display("FAIL %s result u%0d: got %h expected %h", tag, UNR[g], cap[g], exp_s);
        end
        checks++;
        if (ostate[g] !== exp_s || ready[g] !== 1'b1) begin
          errors++; $display("FAIL %s held u%0d: got %h ready %b expected %h ready 1", tag, UNR[g], ostate[g], ready[g], exp_s);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_mask = '1;
    repeat (3) begin
      i_start = 1'($urandom); i_num_rounds = 4'($urandom); i_state = rand_state();
      @(negedge clock);
    end
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if (ready[g] !== 1'b1 || done[g] !== 1'b0 || ostate[g] !== '0 || ridx[g] !== 4'd0) begin
        errors++;
        $display("FAIL reset u%0d: got ready %b done %b idx %0d state %h expected 1 0 0 zero", UNR[g], ready[g], done[g], ridx[g], ostate[g]);
      end
    end
    i_start = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_full_perm();
    do_operation('1, 4'd12, '0, "p12_zero");
    do_operation('1, 4'd12, rand_state(), "p12_rand");
  endtask

  task automatic test_short_ops();
    do_operation(6'b001000, 4'd6, rand_state(), "p6_u4");
    do_operation(6'b001000, 4'd8, rand_state(), "p8_u4");
  endtask

  task automatic test_single_round();
    t_state_array pre, expv;
    pre = {64'h4b, 64'h4b, 64'hffff_ffff_ffff_ffb4, 64'h4b, 64'h0};
    expv[0] = pre[0] ^ rotr(pre[0], 19) ^ rotr(pre[0], 28);
    expv[1] = pre[1] ^ rotr(pre[1], 61) ^ rotr(pre[1], 39);
    expv[2] = pre[2] ^ rotr(pre[2], 1)  ^ rotr(pre[2], 6);
    expv[3] = pre[3] ^ rotr(pre[3], 10) ^ rotr(pre[3], 17);
    expv[4] = pre[4] ^ rotr(pre[4], 7)  ^ rotr(pre[4], 41);
    do_operation(6'b001000, 4'd1, '0, "p1_u4");
    checks++;
    if (cap[3] !== expv) begin
      errors++; $display("FAIL p1_from_prepl: got %h expected %h", cap[3], expv);
    end
  endtask

  task automatic test_back_to_back();
    t_state_array a, b, exp_a, exp_b;
    int cyc;
    a = rand_state(); b = rand_state();
    exp_a = model_perm(a, 8); exp_b = model_perm(b, 6);
    @(negedge clock);
    start_mask = 6'b001000; i_start = 1'b1; i_num_rounds = 4'd8; i_state = a;
    @(negedge clock);
    cyc = 0;
    while (done[3] !== 1'b1 && cyc < 10) begin
      i_num_rounds = 4'($urandom); i_state = rand_state();
      @(negedge clock); cyc++;
    end
    checks++;
    if (cyc != 2) begin
      errors++; $display("FAIL b2b_first_latency: got %0d expected 2", cyc);
    end
    checks++;
    if (ostate[3] !== exp_a || ready[3] !== 1'b1) begin
      errors++; $display("FAIL b2b_first_result: got %h ready %b expected %h ready 1", ostate[3], ready[3], exp_a);
    end
    i_num_rounds = 4'd6; i_state = b;
    @(negedge clock);
    i_start = 1'b0; i_state = rand_state();
    checks++;
    if (ready[3] !== 1'b0 || done[3] !== 1'b0) begin
      errors++; $display("FAIL b2b_no_bubble: got ready %b done %b expected 0 0", ready[3], done[3]);
    end
    cyc = 0;
    while (done[3] !== 1'b1 && cyc < 10) begin
      @(negedge clock); cyc++;
    end
    checks++;
    if (cyc != 2) begin
      errors++; $display("FAIL b2b_second_latency: got %0d expected 2", cyc);
    end
    checks++;
    if (ostate[3] !== exp_b) begin
      errors++; $display("FAIL b2b_second_result: got %h expected %h", ostate[3], exp_b);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_abort();
    int ndone;
    @(negedge clock);
    start_mask = 6'b001001; i_start = 1'b1; i_num_rounds = 4'd6; i_state = rand_state();
    @(negedge clock);
    i_start = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      if (start_mask[g]) begin
        checks++;
        if (ready[g] !== 1'b1 || done[g] !== 1'b0 || ostate[g] !== '0 || ridx[g] !== 4'd0) begin
          errors++;
          $display("FAIL abort_reset u%0d: got ready %b done %b idx %0d state %h expected 1 0 0 zero", UNR[g], ready[g], done[g], ridx[g], ostate[g]);
        end
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    ndone = 0;
    repeat (14) begin
      @(negedge clock);
      if (done[0] === 1'b1 || done[3] === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", ndone);
    end
    do_operation(6'b001001, 4'($urandom_range(1, 12)), rand_state(), "after_abort");
  endtask

  task automatic test_passthrough_clamp();
    t_state_array s;
    t_state_array cap12 [NDUT];
    s = rand_state();
    do_operation('1, 4'd0, s, "n0_pass");
    do_operation('1, 4'd12, s, "n12_ref");
    for (int g = 0; g < NDUT; g++) cap12[g] = cap[g];
    do_operation('1, 4'd15, s, "n15_clamp");
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if (cap[g] !== cap12[g]) begin
        errors++; $display("FAIL n15_eq_n12 u%0d: got %h expected %h", UNR[g], cap[g], cap12[g]);
      end
    end
  endtask

  task automatic test_random();
    repeat (5) do_operation('1, 4'($urandom), rand_state(), "random");
  endtask

  initial begin
    i_start = 1'b0; start_mask = '0; i_num_rounds = '0; i_state = '0;
    test_reset();
    test_full_perm();
    test_short_ops();
    test_single_round();
    test_back_to_back();
    test_reset_abort();
    test_passthrough_clamp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
